// File: rtl/display_pkg.sv
// Shared display-path definitions: default geometry, channel indices, FSM states.
package display_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_CH_DEF = 3;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/lowest_set_sel.sv
// Finds the lowest set bit of a channel mask: found flag, its index, and a
// one-hot vector the caller uses to clear that bit.
module lowest_set_sel #(
  parameter int NUM_CH = 3,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] mask_i,
  output logic              found_o,
  output logic [CH_W-1:0]   idx_o,
  output logic [NUM_CH-1:0] onehot_o
);

  // Scan high to low so the last hit (lowest index) wins.
  always_comb begin
    found_o  = |mask_i;
    idx_o    = '0;
    onehot_o = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o       = CH_W'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_channel_serializer.sv
// Takes one pixel (NUM_CH components) per handshake and emits the enabled
// components one per cycle, lowest channel first, on a registered output.
module pixel_channel_serializer
  import display_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NUM_CH = NUM_CH_DEF,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [NUM_CH*DATA_W-1:0] InData,
  input  logic [NUM_CH-1:0]        InMask,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [DATA_W-1:0]        OutData,
  output logic [CH_W-1:0]          OutChan,
  output logic                     OutLast
);

  ser_state_e                state_q, state_d;
  logic [NUM_CH*DATA_W-1:0]  pix_q, pix_d;
  logic [NUM_CH-1:0]         rem_q, rem_d;
  logic [DATA_W-1:0]         odata_q, odata_d;
  logic [CH_W-1:0]           ochan_q, ochan_d;

  logic                      out_valid, rem_empty, out_hs, accept;
  logic [NUM_CH-1:0]         src_mask;
  logic [NUM_CH*DATA_W-1:0]  src_data;
  logic                      sel_found;
  logic [CH_W-1:0]           sel_idx;
  logic [NUM_CH-1:0]         sel_onehot;

  assign out_valid = (state_q == EMIT);
  assign rem_empty = (rem_q == '0);
  assign out_hs    = out_valid & OutReady;

  // A new pixel fits when nothing is held, or when the last component of the
  // held pixel leaves this very cycle; InValid deliberately plays no part.
  assign InReady = ~Reset & ((state_q == IDLE) | (out_hs & rem_empty));
  assign accept  = InValid & InReady;

  // An accepted pixel always supplies the next component; otherwise the
  // remaining bits of the held pixel do.
  assign src_mask = accept ? InMask : rem_q;
  assign src_data = accept ? InData : pix_q;

  lowest_set_sel #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_sel (
    .mask_i   (src_mask),
    .found_o  (sel_found),
    .idx_o    (sel_idx),
    .onehot_o (sel_onehot)
  );

  // Next-state: hold by default, load the lowest pending channel on advance.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    rem_d   = rem_q;
    odata_d = odata_q;
    ochan_d = ochan_q;
    unique case (state_q)
      IDLE: begin
        // Zero-mask pixels are consumed here and simply vanish.
        if (accept && sel_found) begin
          state_d = EMIT;
          pix_d   = src_data;
          rem_d   = src_mask & ~sel_onehot;
          odata_d = src_data[int'(sel_idx)*DATA_W +: DATA_W];
          ochan_d = sel_idx;
        end
      end
      EMIT: begin
        if (out_hs) begin
          if (sel_found && (!rem_empty || accept)) begin
            pix_d   = src_data;
            rem_d   = src_mask & ~sel_onehot;
            odata_d = src_data[int'(sel_idx)*DATA_W +: DATA_W];
            ochan_d = sel_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any held pixel.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      rem_q   <= '0;
      odata_q <= '0;
      ochan_q <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      rem_q   <= rem_d;
      odata_q <= odata_d;
      ochan_q <= ochan_d;
    end
  end

  assign OutValid = out_valid;
  assign OutData  = odata_q;
  assign OutChan  = ochan_q;
  assign OutLast  = out_valid & rem_empty;

endmodule

// File: tb/tb_pixel_channel_serializer.sv
// Scoreboard bench: stimulus pushes hand-computed components, a negedge
// monitor compares whatever the serializer presents.
module tb_pixel_channel_serializer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid, InReady;
  logic [23:0] InData;
  logic [2:0]  InMask;
  logic        OutValid, OutReady, OutLast;
  logic [7:0]  OutData;
  logic [1:0]  OutChan;

  // Wider instance: 4 channels of 10 bits.
  logic        in4_valid, in4_ready;
  logic [39:0] in4_data;
  logic [3:0]  in4_mask;
  logic        out4_valid, out4_ready, out4_last;
  logic [9:0]  out4_data;
  logic [1:0]  out4_chan;

  always #5 Clock = ~Clock;

  pixel_channel_serializer dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady), .InData(InData), .InMask(InMask),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .OutChan(OutChan), .OutLast(OutLast)
  );

  pixel_channel_serializer #(.DATA_W(10), .NUM_CH(4)) dut4 (
    .Clock(Clock), .Reset(Reset),
    .InValid(in4_valid), .InReady(in4_ready), .InData(in4_data), .InMask(in4_mask),
    .OutValid(out4_valid), .OutReady(out4_ready), .OutData(out4_data),
    .OutChan(out4_chan), .OutLast(out4_last)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] ch;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   hs_cyc[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push(input logic [7:0] d, input logic [1:0] ch, input logic last);
    exp_t e;
    e.d = d; e.ch = ch; e.last = last;
    q.push_back(e);
  endfunction

  always @(posedge Clock) cyc++;

  // Monitor: compare presented component against queue head; pop on handshake.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (OutValid) begin
        if (q.size() == 0) begin
          chk("unexpected_component", {OutChan, OutData}, 64'hDEAD);
        end else begin
          chk("out_data", OutData, q[0].d);
          chk("out_chan", OutChan, q[0].ch);
          chk("out_last", OutLast, q[0].last);
          chk("in_ready_emit", InReady, OutReady & q[0].last);
          if (OutReady) begin
            void'(q.pop_front());
            hs_cyc.push_back(cyc);
          end
        end
      end else begin
        chk("in_ready_idle", InReady, 1'b1);
      end
    end
  end

  // Present a pixel until accepted; returns at posedge+1 of the accept edge.
  task automatic send(input logic [23:0] d, input logic [2:0] m);
    int n = 0;
    InValid = 1'b1; InData = d; InMask = m;
    forever begin
      @(negedge Clock);
      if (InReady) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 0, 1);
        InValid = 1'b0;
        return;
      end
      @(posedge Clock);
    end
    @(posedge Clock); #1;
    InValid = 1'b0; InMask = '0;
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(posedge Clock); #1;
      if (q.size() == 0 && !OutValid) break;
      n++;
      if (n > 50) break;
    end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    Reset = 1'b1; OutReady = 1'b1; InValid = 1'b0; InData = '0; InMask = '0;
    in4_valid = 1'b0; in4_data = '0; in4_mask = '0; out4_ready = 1'b1;

    // Reset state
    @(posedge Clock); @(negedge Clock);
    chk("rst_in_ready", InReady, 0);
    chk("rst_out_valid", OutValid, 0);
    chk("rst_out_data", OutData, 0);
    chk("rst_out_chan", OutChan, 0);
    chk("rst_out_last", OutLast, 0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    // 1: full pixel R,G,B
    push(8'h11, 2'd0, 1'b0); push(8'h22, 2'd1, 1'b0); push(8'h33, 2'd2, 1'b1);
    base = hs_cyc.size();
    send(24'h332211, 3'b111);
    chk("latency_valid", OutValid, 1);
    chk("latency_data", OutData, 8'h11);
    drain();
    chk("t1_count", hs_cyc.size() - base, 3);
    if (hs_cyc.size() - base == 3) chk("t1_span", hs_cyc[base+2] - hs_cyc[base], 2);

    // 2: back-to-back 111 then 101, no bubble
    push(8'h44, 2'd0, 1'b0); push(8'h55, 2'd1, 1'b0); push(8'h66, 2'd2, 1'b1);
    push(8'h77, 2'd0, 1'b0); push(8'h99, 2'd2, 1'b1);
    base = hs_cyc.size();
    send(24'h665544, 3'b111);
    send(24'h998877, 3'b101);
    drain();
    chk("t2_count", hs_cyc.size() - base, 5);
    if (hs_cyc.size() - base == 5) chk("t2_span", hs_cyc[base+4] - hs_cyc[base], 4);

    // 3: zero-mask pixel between two full pixels is dropped silently
    push(8'hA0, 2'd0, 1'b0); push(8'hB0, 2'd1, 1'b0); push(8'hC0, 2'd2, 1'b1);
    push(8'hF1, 2'd0, 1'b0); push(8'hF2, 2'd1, 1'b0); push(8'hF3, 2'd2, 1'b1);
    base = hs_cyc.size();
    send(24'hC0B0A0, 3'b111);
    send(24'hFFFFFF, 3'b000);
    send(24'hF3F2F1, 3'b111);
    drain();
    chk("t3_count", hs_cyc.size() - base, 6);

    // 4: OutReady 1,0,0,1 during a pixel
    push(8'h01, 2'd0, 1'b0); push(8'h02, 2'd1, 1'b0); push(8'h03, 2'd2, 1'b1);
    base = hs_cyc.size();
    send(24'h030201, 3'b111);
    @(posedge Clock); #1 OutReady = 1'b0;
    @(posedge Clock); #1;
    chk("t4_stall_in_ready", InReady, 0);
    @(posedge Clock); #1 OutReady = 1'b1;
    drain();
    chk("t4_count", hs_cyc.size() - base, 3);

    // 5: reset after first component of a full pixel
    push(8'h0A, 2'd0, 1'b0);
    send(24'h0C0B0A, 3'b111);
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock);
    chk("t5_rst_in_ready", InReady, 0);
    @(posedge Clock); #1;
    chk("t5_out_valid", OutValid, 0);
    chk("t5_out_data", OutData, 0);
    chk("t5_out_chan", OutChan, 0);
    chk("t5_out_last", OutLast, 0);
    chk("t5_in_ready", InReady, 0);
    chk("t5_queue", q.size(), 0);
    q.delete();
    Reset = 1'b0;
    push(8'h5A, 2'd0, 1'b0); push(8'h5B, 2'd1, 1'b0); push(8'h5C, 2'd2, 1'b1);
    send(24'h5C5B5A, 3'b111);
    drain();

    // 6: 4 channels x 10 bits, only channel 3 enabled
    in4_valid = 1'b1;
    in4_data  = {10'h2A5, 10'h111, 10'h0F0, 10'h3C3};
    in4_mask  = 4'b1000;
    @(negedge Clock);
    chk("t6_in_ready", in4_ready, 1);
    @(posedge Clock); #1;
    in4_valid = 1'b0;
    chk("t6_valid", out4_valid, 1);
    chk("t6_chan", out4_chan, 3);
    chk("t6_last", out4_last, 1);
    chk("t6_data", out4_data, 10'h2A5);
    @(posedge Clock); #1;
    chk("t6_done", out4_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
